// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed little-endian 32-bit data memory.
// Adds byte/half/word access, sign/zero extension, sub-word read-modify-write and error checks.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [63:0] load_ext;
    logic [31:0] merged;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^req_wdata[63:32];

    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (|req_addr[1:0]))
                | (req_addr >= 64'(MEM_BYTES));
    end

    // Lane extraction and extension for loads; word loads are always zero-extended.
    always_comb begin
        unique case (lane_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   load_ext = unsigned_q ? {56'b0, lane_byte}
                                           : {{56{lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = unsigned_q ? {48'b0, lane_half}
                                           : {{48{lane_half[15]}}, lane_half};
            default: load_ext = {32'b0, mem_rdata};
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        req_ready    = (state_q == StIdle);
        resp_valid   = 1'b0;
        resp_rdata   = 64'b0;
        resp_error   = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_wdata    = 32'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr & ~64'h3;
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata[31:0];
                    rdata_d    = 64'b0;
                    error_d    = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_write) begin
                        state_d = StLoad;
                    end else if (req_size == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRead;
                    end
                end
            end
            StLoad: begin
                mem_read_en = 1'b1;
                rdata_d     = load_ext;
                state_d     = StResp;
            end
            StRmwRead: begin
                // Reuse the store-data register to hold the merged word for WRITE.
                mem_read_en = 1'b1;
                wdata_d     = merged;
                state_d     = StWrite;
            end
            StWrite: begin
                mem_write_en = 1'b1;
                mem_wdata    = wdata_q;
                state_d      = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_error = error_q;
                rdata_d    = 64'b0;
                error_d    = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_addr = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            size_q     <= 2'b0;
            unsigned_q <= 1'b0;
            addr_q     <= 64'b0;
            lane_q     <= 2'b0;
            wdata_q    <= 32'b0;
            rdata_q    <= 64'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of requests plus hand sequences,
// with a byte-array memory model and a response scoreboard.
module tb_load_store_unit;

    localparam int unsigned MemBytes = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [63:0] resp_rdata, mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_read_en, mem_write_en;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MemBytes)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    // Memory model: combinational read, 4-byte write on the rising edge.
    logic [7:0] mem [MemBytes];
    logic [7:0] snap [MemBytes];
    logic       mem_init = 1'b1;

    always_comb begin
        mem_rdata = 32'b0;
        if (mem_addr < 64'(MemBytes)) begin
            for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = mem[int'(mem_addr[31:0]) + k];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MemBytes); i++) mem[i] <= 8'(i);
        end else if (mem_write_en && mem_addr < 64'(MemBytes)) begin
            for (int k = 0; k < 4; k++) mem[int'(mem_addr[31:0]) + k] <= mem_wdata[8*k +: 8];
        end
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    logic prev_valid = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endfunction

    function automatic vec_t mk(string name, logic wr, logic [1:0] size, logic uns,
                                logic [63:0] addr, logic [63:0] wdata,
                                logic [63:0] exp_rdata, logic exp_err, int lat);
        vec_t v;
        v.name = name; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_read_en || mem_write_en) en_cnt++;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious resp_valid", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, " rdata"}, resp_rdata, e.rdata);
                check({e.name, " error"}, 64'(resp_error), 64'(e.err));
                check({e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end else if (prev_valid) begin
            check("rdata cleared after resp", resp_rdata, 64'd0);
            check("error cleared after resp", 64'(resp_error), 64'd0);
        end
        prev_valid = resp_valid;
    end

    // Called at posedge+1; returns at acceptance edge +1 with the request pushed.
    task automatic issue(input vec_t v, output int waits);
        waits        = 0;
        req_write    = v.wr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        while (!req_ready && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!req_ready) check({v.name, " ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        exp_q.push_back('{name: v.name, rdata: v.exp_rdata, err: v.exp_err, lat: v.lat, acc: cyc});
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({name, " response timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int waits;
        int en0;
        int diffs;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b0; req_unsigned = 1'b0;
        req_addr = 64'b0; req_wdata = 64'b0;

        vecs.push_back(mk("lw 8",      1'b0, 2'b10, 1'b0, 64'h8,  64'h0, 64'h0000_0000_0B0A_0908, 1'b0, 2));
        vecs.push_back(mk("sb 5",      1'b1, 2'b00, 1'b0, 64'h5,  64'hFF, 64'h0, 1'b0, 3));
        vecs.push_back(mk("lb 5",      1'b0, 2'b00, 1'b0, 64'h5,  64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2));
        vecs.push_back(mk("lbu 5",     1'b0, 2'b00, 1'b1, 64'h5,  64'h0, 64'h0000_0000_0000_00FF, 1'b0, 2));
        vecs.push_back(mk("lw 4",      1'b0, 2'b10, 1'b0, 64'h4,  64'h0, 64'h0000_0000_0706_FF04, 1'b0, 2));
        vecs.push_back(mk("sh A",      1'b1, 2'b01, 1'b0, 64'hA,  64'h8001, 64'h0, 1'b0, 3));
        vecs.push_back(mk("lw 8 post", 1'b0, 2'b10, 1'b0, 64'h8,  64'h0, 64'h0000_0000_8001_0908, 1'b0, 2));
        vecs.push_back(mk("lh A",      1'b0, 2'b01, 1'b0, 64'hA,  64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 2));
        vecs.push_back(mk("lhu A",     1'b0, 2'b01, 1'b1, 64'hA,  64'h0, 64'h0000_0000_0000_8001, 1'b0, 2));
        vecs.push_back(mk("lb B",      1'b0, 2'b00, 1'b0, 64'hB,  64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2));
        vecs.push_back(mk("lh 2",      1'b0, 2'b01, 1'b0, 64'h2,  64'h0, 64'h0000_0000_0000_0302, 1'b0, 2));
        vecs.push_back(mk("err lw 6",  1'b0, 2'b10, 1'b0, 64'h6,  64'h0, 64'h0, 1'b1, 1));
        vecs.push_back(mk("err sh 3",  1'b1, 2'b01, 1'b0, 64'h3,  64'hFFFF, 64'h0, 1'b1, 1));
        vecs.push_back(mk("err lb 64", 1'b0, 2'b00, 1'b0, 64'h40, 64'h0, 64'h0, 1'b1, 1));
        vecs.push_back(mk("err sz 11", 1'b1, 2'b11, 1'b0, 64'h0,  64'hFFFF_FFFF, 64'h0, 1'b1, 1));

        // Reset and memory initialisation (byte i = i).
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset mem_addr", mem_addr, 64'd0);
        check("reset mem_en", 64'({mem_read_en, mem_write_en}), 64'd0);
        check("reset mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            en0 = en_cnt;
            snap = mem;
            issue(vecs[i], waits);
            wait_done(vecs[i].name);
            if (vecs[i].exp_err) begin
                check({vecs[i].name, " mem enables"}, 64'(en_cnt - en0), 64'd0);
                diffs = 0;
                for (int b = 0; b < int'(MemBytes); b++) if (mem[b] !== snap[b]) diffs++;
                check({vecs[i].name, " mem unchanged"}, 64'(diffs), 64'd0);
            end
        end

        // Back-to-back with req_valid held: sw then lw to the same word.
        issue(mk("sw C", 1'b1, 2'b10, 1'b0, 64'hC, 64'hDEAD_BEEF, 64'h0, 1'b0, 2), waits);
        issue(mk("lw C", 1'b0, 2'b10, 1'b0, 64'hC, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 2), waits);
        check("ready low cycles", 64'(waits), 64'd2);
        wait_done("lw C");

        // Byte store into the top lane, then word readback.
        issue(mk("sb F", 1'b1, 2'b00, 1'b0, 64'hF, 64'h1234_5680, 64'h0, 1'b0, 3), waits);
        wait_done("sb F");
        issue(mk("lw C post", 1'b0, 2'b10, 1'b0, 64'hC, 64'h0, 64'h0000_0000_80AD_BEEF, 1'b0, 2),
              waits);
        wait_done("lw C post");

        // Reset during RMW_READ of sb 20 aborts the store.
        issue(mk("sb 14", 1'b1, 2'b00, 1'b0, 64'h14, 64'hAA, 64'h0, 1'b0, 3), waits);
        check("rmw read_en", 64'(mem_read_en), 64'd1);
        rst = 1'b0;
        #1;
        check("abort mem_en", 64'({mem_read_en, mem_write_en}), 64'd0);
        check("abort mem_addr", mem_addr, 64'd0);
        check("abort req_ready", 64'(req_ready), 64'd1);
        exp_q.delete();
        req_write = 1'b0; req_size = 2'b10; req_addr = 64'h20; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ignored in reset", mem_addr, 64'd0);
        check("byte 20 kept", 64'(mem[20]), 64'h14);
        issue(mk("lw 14", 1'b0, 2'b10, 1'b0, 64'h14, 64'h0, 64'h0000_0000_1716_1514, 1'b0, 2),
              waits);
        wait_done("lw 14");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
